// File: rtl/bp_common_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_common_pkg
// Brief  : Platform address map, device IDs and ordering-entry types.
// Rev    : 1.0
// ============================================================================
package bp_common_pkg;

    localparam int c_dev_id_width = 8;
    typedef logic [c_dev_id_width-1:0] bp_dev_id_t;

    localparam bp_dev_id_t c_dev_boot  = 8'd0;
    localparam bp_dev_id_t c_dev_host  = 8'd1;
    localparam bp_dev_id_t c_dev_cfg   = 8'd2;
    localparam bp_dev_id_t c_dev_clint = 8'd3;
    localparam bp_dev_id_t c_dev_cache = 8'd4;

    localparam logic [63:0] c_dram_base   = 64'h00_8000_0000;
    localparam logic [63:0] c_coproc_base = 64'h10_0000_0000;
    localparam logic [63:0] c_global_base = 64'h20_0000_0000;

    localparam int c_local_id_lsb   = 20;
    localparam int c_local_id_width = 4;

    typedef enum logic [2:0] {
        e_region_local  = 3'd0,
        e_region_dram   = 3'd1,
        e_region_coproc = 3'd2,
        e_region_global = 3'd3,
        e_region_error  = 3'd4
    } bp_dispatch_region_e;

    typedef struct packed {
        bp_dev_id_t dest;
        logic       err;
    } bp_order_entry_s;

endpackage : bp_common_pkg
`default_nettype wire

// File: rtl/bp_me_addr_decode.sv
`default_nettype none
// ============================================================================
// Module : bp_me_addr_decode
// Brief  : Combinational physical address -> {dest channel, err} decode.
// Rev    : 1.0
// ============================================================================
module bp_me_addr_decode
    import bp_common_pkg::*;
#(
    parameter int paddr_width_p   = 40,
    parameter int num_local_dev_p = 5
) (
    input  logic [paddr_width_p-1:0] addr_i,
    output bp_order_entry_s          entry_o
);

    logic [63:0]                 w_addr;
    logic [c_local_id_width-1:0] w_local_id;
    bp_dispatch_region_e         w_region;

    assign w_addr     = 64'(addr_i);
    assign w_local_id = addr_i[c_local_id_lsb +: c_local_id_width];

    // Priority order matters: the upper regions overlap the local ID field.
    always_comb begin
        w_region = e_region_error;
        if (w_addr >= c_global_base)
            w_region = e_region_global;
        else if (w_addr >= c_coproc_base)
            w_region = e_region_coproc;
        else if (w_addr >= c_dram_base)
            w_region = e_region_dram;
        else if (32'(w_local_id) < num_local_dev_p)
            w_region = e_region_local;
    end

    always_comb begin
        entry_o.dest = '0;
        entry_o.err  = 1'b0;
        case (w_region)
            e_region_local:  entry_o.dest = bp_dev_id_t'(w_local_id);
            e_region_dram:   entry_o.dest = bp_dev_id_t'(num_local_dev_p);
            e_region_coproc: entry_o.dest = bp_dev_id_t'(num_local_dev_p + 1);
            e_region_global: entry_o.dest = bp_dev_id_t'(num_local_dev_p + 2);
            default:         entry_o.err  = 1'b1;
        endcase
    end

endmodule : bp_me_addr_decode
`default_nettype wire

// File: rtl/bp_me_addr_dispatch.sv
`default_nettype none
// ============================================================================
// Module : bp_me_addr_dispatch
// Brief  : Routes ME commands to device channels, returns responses in order.
//          Optional per-channel fire counters: BP_ME_ADDR_DISPATCH_PERF_EN.
// Rev    : 1.0
// ============================================================================
module bp_me_addr_dispatch
    import bp_common_pkg::*;
#(
    parameter int paddr_width_p     = 40,
    parameter int data_width_p      = 64,
    parameter int num_local_dev_p   = 5,
    parameter int num_dev_p         = num_local_dev_p + 3,
    parameter int max_outstanding_p = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              cmd_v_i,
    input  logic [paddr_width_p-1:0]          cmd_addr_i,
    input  logic                              cmd_we_i,
    input  logic [data_width_p-1:0]           cmd_data_i,
    output logic                              cmd_ready_o,
    output logic [num_dev_p-1:0]              dev_v_o,
    output logic [paddr_width_p-1:0]          dev_addr_o,
    output logic                              dev_we_o,
    output logic [data_width_p-1:0]           dev_data_o,
    input  logic [num_dev_p-1:0]              dev_ready_i,
    input  logic [num_dev_p-1:0]              dev_resp_v_i,
    input  logic [num_dev_p*data_width_p-1:0] dev_resp_data_i,
    output logic [num_dev_p-1:0]              dev_resp_ready_o,
    output logic                              resp_v_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              resp_err_o,
    input  logic                              resp_ready_i,
    output logic [num_dev_p*32-1:0]           perf_cnt_o
);

    localparam int c_ptr_width = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int c_cnt_width = $clog2(max_outstanding_p + 1);
    localparam logic [c_ptr_width-1:0] c_ptr_one  = c_ptr_width'(1);
    localparam logic [c_cnt_width-1:0] c_cnt_one  = c_cnt_width'(1);
    localparam logic [c_cnt_width-1:0] c_cnt_full = c_cnt_width'(max_outstanding_p);

    bp_order_entry_s             w_dec;
    bp_order_entry_s             w_head;
    logic                        w_accept;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_out_fire;
    logic                        w_head_resp_v;
    logic [num_dev_p-1:0]        w_out_onehot;
    logic [num_dev_p-1:0]        w_head_onehot;
    logic [data_width_p-1:0]     w_resp_data;

    logic                        r_out_v;
    bp_dev_id_t                  r_dest;
    logic [paddr_width_p-1:0]    r_addr;
    logic                        r_we;
    logic [data_width_p-1:0]     r_data;
    bp_order_entry_s             r_fifo [max_outstanding_p];
    logic [c_ptr_width-1:0]      r_wr_ptr;
    logic [c_ptr_width-1:0]      r_rd_ptr;
    logic [c_cnt_width-1:0]      r_count;

    bp_me_addr_decode #(
        .paddr_width_p   (paddr_width_p),
        .num_local_dev_p (num_local_dev_p)
    ) u_decode (
        .addr_i  (cmd_addr_i),
        .entry_o (w_dec)
    );

    assign w_full      = (r_count == c_cnt_full);
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_out_fire  = |(w_out_onehot & dev_ready_i);
    assign cmd_ready_o = ~w_full & (~r_out_v | w_out_fire);
    assign w_accept    = cmd_v_i & cmd_ready_o;

    // Error heads select no channel, so their response data falls out as zero.
    always_comb begin
        w_out_onehot  = '0;
        w_head_onehot = '0;
        w_resp_data   = '0;
        for (int i = 0; i < num_dev_p; i++) begin
            w_out_onehot[i]  = r_out_v && (r_dest == bp_dev_id_t'(i));
            w_head_onehot[i] = !w_empty && !w_head.err && (w_head.dest == bp_dev_id_t'(i));
            if (w_head_onehot[i])
                w_resp_data = w_resp_data | dev_resp_data_i[i*data_width_p +: data_width_p];
        end
    end

    assign w_head_resp_v    = |(w_head_onehot & dev_resp_v_i);
    assign dev_v_o          = w_out_onehot;
    assign dev_addr_o       = r_addr;
    assign dev_we_o         = r_we;
    assign dev_data_o       = r_data;
    assign dev_resp_ready_o = w_head_onehot & {num_dev_p{resp_ready_i}};
    assign resp_v_o         = !w_empty && (w_head.err || w_head_resp_v);
    assign resp_err_o       = !w_empty && w_head.err;
    assign resp_data_o      = w_resp_data;
    assign w_pop            = resp_v_o & resp_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out_v <= 1'b0;
            r_dest  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_data  <= '0;
        end else if (w_accept && !w_dec.err) begin
            r_out_v <= 1'b1;
            r_dest  <= w_dec.dest;
            r_addr  <= cmd_addr_i;
            r_we    <= cmd_we_i;
            r_data  <= cmd_data_i;
        end else if (w_out_fire) begin
            r_out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < max_outstanding_p; i++)
                r_fifo[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_dec;
                r_wr_ptr         <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef BP_ME_ADDR_DISPATCH_PERF_EN
    for (genvar i = 0; i < num_dev_p; i++) begin : g_perf
        logic [31:0] r_cnt;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)
                r_cnt <= '0;
            else if (w_out_onehot[i] && dev_ready_i[i])
                r_cnt <= r_cnt + 32'd1;
        end
        assign perf_cnt_o[i*32 +: 32] = r_cnt;
    end : g_perf
`else
    assign perf_cnt_o = '0;
`endif

endmodule : bp_me_addr_dispatch
`default_nettype wire

// File: tb/tb_bp_me_addr_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_bp_me_addr_dispatch
// Brief  : Directed + randomized self-checking bench with an in-order model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bp_me_addr_dispatch;

    localparam int PAW = 40;
    localparam int DW  = 64;
    localparam int NLD = 5;
    localparam int ND  = NLD + 3;
    localparam int MO  = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              cmd_v_i;
    logic [PAW-1:0]    cmd_addr_i;
    logic              cmd_we_i;
    logic [DW-1:0]     cmd_data_i;
    logic              cmd_ready_o;
    logic [ND-1:0]     dev_v_o;
    logic [PAW-1:0]    dev_addr_o;
    logic              dev_we_o;
    logic [DW-1:0]     dev_data_o;
    logic [ND-1:0]     dev_ready_i;
    logic [ND-1:0]     dev_resp_v_i;
    logic [ND*DW-1:0]  dev_resp_data_i;
    logic [ND-1:0]     dev_resp_ready_o;
    logic              resp_v_o;
    logic [DW-1:0]     resp_data_o;
    logic              resp_err_o;
    logic              resp_ready_i;
    logic [ND*32-1:0]  perf_cnt_o;

    always #5 clk_i = ~clk_i;

    bp_me_addr_dispatch #(
        .paddr_width_p     (PAW),
        .data_width_p      (DW),
        .num_local_dev_p   (NLD),
        .num_dev_p         (ND),
        .max_outstanding_p (MO)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .cmd_v_i          (cmd_v_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_we_i         (cmd_we_i),
        .cmd_data_i       (cmd_data_i),
        .cmd_ready_o      (cmd_ready_o),
        .dev_v_o          (dev_v_o),
        .dev_addr_o       (dev_addr_o),
        .dev_we_o         (dev_we_o),
        .dev_data_o       (dev_data_o),
        .dev_ready_i      (dev_ready_i),
        .dev_resp_v_i     (dev_resp_v_i),
        .dev_resp_data_i  (dev_resp_data_i),
        .dev_resp_ready_o (dev_resp_ready_o),
        .resp_v_o         (resp_v_o),
        .resp_data_o      (resp_data_o),
        .resp_err_o       (resp_err_o),
        .resp_ready_i     (resp_ready_i),
        .perf_cnt_o       (perf_cnt_o)
    );

    typedef struct {
        int dest;
        bit err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_perf[ND];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled before the next rise.
    task automatic cyc();
        @(negedge clk_i);
        #1;
    endtask

    function automatic void ref_decode(input logic [39:0] addr, output int dest, output bit err);
        int id;
        err  = 1'b0;
        dest = 0;
        id   = int'(addr[23:20]);
        if (addr >= 40'h20_0000_0000)      dest = NLD + 2;
        else if (addr >= 40'h10_0000_0000) dest = NLD + 1;
        else if (addr >= 40'h00_8000_0000) dest = NLD;
        else if (id < NLD)                 dest = id;
        else                               err  = 1'b1;
    endfunction

    function automatic logic [39:0] gen_addr();
        logic [39:0] a;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: a = {8'h00, 1'b0, r[30:24], 4'($urandom_range(0, NLD-1)), r[19:0]};
            1: a = {4'h0, 4'($urandom_range(0, 15)), 1'b1, r[30:0]};
            2: a = {4'h1, 4'($urandom_range(0, 15)), r};
            3: a = {3'b001, 5'($urandom_range(0, 31)), r};
            default: a = {8'h00, 1'b0, r[30:24], 4'($urandom_range(NLD, 15)), r[19:0]};
        endcase
        return a;
    endfunction

    function automatic logic [ND*32-1:0] exp_perf_vec();
        logic [ND*32-1:0] v;
        v = '0;
`ifdef BP_ME_ADDR_DISPATCH_PERF_EN
        for (int i = 0; i < ND; i++) v[i*32 +: 32] = exp_perf[i];
`endif
        return v;
    endfunction

    task automatic issue(input logic [39:0] addr, input logic we, input logic [DW-1:0] data);
        int d;
        bit e;
        ref_decode(addr, d, e);
        cmd_v_i    = 1'b1;
        cmd_addr_i = addr;
        cmd_we_i   = we;
        cmd_data_i = data;
        #1 chk("cmd_ready_issue", cmd_ready_o, 1);
        cyc();
        cmd_v_i = 1'b0;
        #1;
        chk("dev_v", dev_v_o, e ? 0 : (1 << d));
        if (!e) begin
            chk("dev_addr", dev_addr_o, addr);
            chk("dev_we", dev_we_o, we);
            chk("dev_data", dev_data_o, data);
            exp_perf[d]++;
        end
        exp_q.push_back('{dest: d, err: e});
    endtask

    task automatic respond_head(input logic [DW-1:0] data);
        exp_t x;
        x = exp_q.pop_front();
        resp_ready_i = 1'b1;
        if (!x.err) begin
            dev_resp_v_i[x.dest] = 1'b1;
            dev_resp_data_i[x.dest*DW +: DW] = data;
        end
        #1;
        chk("resp_v", resp_v_o, 1);
        chk("resp_err", resp_err_o, x.err);
        chk("resp_data", resp_data_o, x.err ? 64'h0 : data);
        chk("dev_resp_ready", dev_resp_ready_o, x.err ? 0 : (1 << x.dest));
        cyc();
        dev_resp_v_i = '0;
        resp_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i       = 1'b0;
        cmd_v_i         = 1'b0;
        cmd_addr_i      = '0;
        cmd_we_i        = 1'b0;
        cmd_data_i      = '0;
        dev_ready_i     = '1;
        dev_resp_v_i    = '0;
        dev_resp_data_i = '0;
        resp_ready_i    = 1'b0;
        for (int i = 0; i < ND; i++) exp_perf[i] = 0;

        cyc();
        cyc();
        chk("rst_dev_v", dev_v_o, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_dev_resp_ready", dev_resp_ready_o, 0);
        chk("rst_perf", perf_cnt_o, 0);
        reset_n_i = 1'b1;
        cyc();
        chk("rst_cmd_ready", cmd_ready_o, 1);

        // Host write, dram read, unmapped access.
        issue(40'h00_0010_0008, 1'b1, {$urandom, $urandom});
        respond_head({$urandom, $urandom});
        issue(40'h00_8000_0000, 1'b0, {$urandom, $urandom});
        respond_head({$urandom, $urandom});
        issue(40'h00_0050_0000, 1'b0, {$urandom, $urandom});
        respond_head({$urandom, $urandom});

        // Clint answers before dram but must wait behind it.
        issue(40'h00_8000_0040, 1'b0, 64'h0);
        issue(40'h00_0030_0000, 1'b0, 64'h0);
        resp_ready_i = 1'b1;
        dev_resp_v_i[3] = 1'b1;
        dev_resp_data_i[3*DW +: DW] = 64'hAA;
        #1;
        chk("ooo_resp_v_blocked", resp_v_o, 0);
        chk("ooo_clint_held", dev_resp_ready_o, 1 << 5);
        cyc();
        chk("ooo_still_blocked", resp_v_o, 0);
        dev_resp_v_i[5] = 1'b1;
        dev_resp_data_i[5*DW +: DW] = 64'hBB;
        #1;
        chk("ooo_first_data", resp_data_o, 64'hBB);
        chk("ooo_first_ready", dev_resp_ready_o, 1 << 5);
        cyc();
        dev_resp_v_i[5] = 1'b0;
        #1;
        chk("ooo_second_v", resp_v_o, 1);
        chk("ooo_second_data", resp_data_o, 64'hAA);
        chk("ooo_second_ready", dev_resp_ready_o, 1 << 3);
        cyc();
        dev_resp_v_i = '0;
        resp_ready_i = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #1 chk("ooo_drained", resp_v_o, 0);

        // Fill the ordering FIFO, then one pop admits the fifth command.
        for (int i = 0; i < MO; i++) issue(gen_addr() & 40'h0F_FFFF_FFFF | 40'h00_8000_0000, 1'b0, {$urandom, $urandom});
        cmd_v_i    = 1'b1;
        cmd_addr_i = 40'h00_8000_1000;
        cmd_we_i   = 1'b1;
        cmd_data_i = 64'h5555;
        #1 chk("full_ready_low", cmd_ready_o, 0);
        cyc();
        chk("full_ready_low_reg_free", cmd_ready_o, 0);
        respond_head({$urandom, $urandom});
        chk("full_ready_after_pop", cmd_ready_o, 1);
        cyc();
        cmd_v_i = 1'b0;
        #1 chk("full_fifth_dev_v", dev_v_o, 1 << 5);
        exp_q.push_back('{dest: 5, err: 1'b0});
        exp_perf[5]++;
        for (int i = 0; i < MO; i++) respond_head({$urandom, $urandom});

        // Coproc command stalled by its device.
        dev_ready_i[6] = 1'b0;
        issue(40'h10_0000_1000, 1'b1, 64'hC0FF_EE00_1234_5678);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_dev_v", dev_v_o, 1 << 6);
            chk("stall_addr", dev_addr_o, 40'h10_0000_1000);
            chk("stall_data", dev_data_o, 64'hC0FF_EE00_1234_5678);
            chk("stall_cmd_ready", cmd_ready_o, 0);
        end
        dev_ready_i[6] = 1'b1;
        cyc();
        chk("stall_fired", dev_v_o, 0);
        respond_head({$urandom, $urandom});

        // Random bursts against the in-order model.
        for (int it = 0; it < 15; it++) begin
            int k;
            k = $urandom_range(1, MO);
            for (int j = 0; j < k; j++) issue(gen_addr(), 1'($urandom), {$urandom, $urandom});
            for (int j = 0; j < k; j++) respond_head({$urandom, $urandom});
        end
        chk("perf_after_random", perf_cnt_o, exp_perf_vec());

        // Asynchronous reset in the middle of a stall.
        dev_ready_i[6] = 1'b0;
        issue(40'h10_0000_2000, 1'b0, 64'h1);
        cmd_v_i    = 1'b1;
        cmd_addr_i = 40'h00_8000_2000;
        #1 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_dev_v", dev_v_o, 0);
        chk("mid_rst_resp_v", resp_v_o, 0);
        chk("mid_rst_resp_err", resp_err_o, 0);
        chk("mid_rst_dev_resp_ready", dev_resp_ready_o, 0);
        chk("mid_rst_perf", perf_cnt_o, 0);
        cmd_v_i     = 1'b0;
        dev_ready_i = '1;
        exp_q.delete();
        for (int i = 0; i < ND; i++) exp_perf[i] = 0;
        cyc();
        reset_n_i = 1'b1;
        cyc();
        chk("post_rst_cmd_ready", cmd_ready_o, 1);

        // Three dram fires.
        for (int i = 0; i < 3; i++) begin
            issue(40'h00_8000_0000 + 40'(i * 8), 1'b0, {$urandom, $urandom});
            respond_head({$urandom, $urandom});
        end
        chk("perf_dram3", perf_cnt_o, exp_perf_vec());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bp_me_addr_dispatch
`default_nettype wire
